// File: rtl/period_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : period_meter_pkg
// Description : Shared state encoding and width helper for the period meter.
// Revision    : 1.0 - initial release
// ============================================================================
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        MEASURING = 2'd2
    } state_e;

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : edge_sync
// Description : SYNC_STAGES-deep synchroniser with a registered rising-edge
//               detector; SYNC_STAGES=0 takes the input as already synchronous.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_rise
);

    logic w_sync;
    logic sync_d1_q;
    logic rise_q;
    logic rise_d;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] stage_q;
            logic [SYNC_STAGES-1:0] stage_d;

            always_comb begin
                stage_d[0] = i_in;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign w_sync = stage_q[SYNC_STAGES-1];
        end else begin : g_bypass
            assign w_sync = i_in;
        end
    endgenerate

    assign rise_d = w_sync & ~sync_d1_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_d1_q <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            sync_d1_q <= w_sync;
            rise_q    <= rise_d;
        end
    end

    assign o_rise = rise_q;

endmodule
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// Module      : period_meter
// Description : Counts i_clk cycles between rising edges of i_event and hands
//               each period out on a single-entry valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
module period_meter
    import period_meter_pkg::*;
#(
    parameter  int MAX_CNT     = 255,
    parameter  int SYNC_STAGES = 2,
    localparam int C_CNT_W     = clog2(MAX_CNT + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_event,
    input  logic               i_rdy,
    output logic               o_vld,
    output logic [C_CNT_W-1:0] o_period,
    output logic               o_ovf,
    output logic               o_drop,
    output logic               o_busy
);

    localparam logic [C_CNT_W-1:0] C_MAX = C_CNT_W'(MAX_CNT);
    localparam logic [C_CNT_W-1:0] C_ONE = C_CNT_W'(1);

    state_e             state_q, state_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic [C_CNT_W-1:0] period_q, period_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               vld_q, vld_d;
    logic               ovf_q, ovf_d;
    logic               drop_q, drop_d;
    logic               w_edge;
    logic               w_capture;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_in   (i_event),
        .o_rise (w_edge)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        w_capture  = 1'b0;
        if (!i_en) begin
            state_d    = IDLE;
            cnt_d      = '0;
            ovf_pend_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                    cnt_d   = '0;
                end
                ARMED: begin
                    if (w_edge) begin
                        cnt_d   = C_ONE;
                        state_d = MEASURING;
                    end
                end
                MEASURING: begin
                    if (w_edge) begin
                        w_capture  = 1'b1;
                        cnt_d      = C_ONE;
                        ovf_pend_d = 1'b0;
                    end else if (cnt_q == C_MAX) begin
                        // Saturate: the count stays put and the excess is remembered.
                        ovf_pend_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A capture that finds the slot occupied and not draining is discarded.
    always_comb begin
        vld_d    = vld_q & ~i_rdy;
        period_d = period_q;
        ovf_d    = ovf_q;
        drop_d   = 1'b0;
        if (w_capture) begin
            if (!vld_q || i_rdy) begin
                vld_d    = 1'b1;
                period_d = cnt_q;
                ovf_d    = ovf_pend_q;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            vld_q      <= 1'b0;
            period_q   <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            vld_q      <= vld_d;
            period_q   <= period_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    assign o_vld    = vld_q;
    assign o_period = period_q;
    assign o_ovf    = ovf_q;
    assign o_drop   = drop_q;
    assign o_busy   = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the number of i_clk cycles between successive rising edges of an event input, such as a tick or done stream from a counter or an external strobe.
- Each completed period is presented as a captured result on a valid/ready output port, with an overflow flag.
- Used as the receive-side consumer of tick streams, for rate checking, timeout detection and frequency measurement.

Parameters:
- MAX_CNT, 255, largest period reported exactly. Longer periods saturate and flag overflow. Must be >= 2.
- SYNC_STAGES, 2, number of synchroniser flops on i_event. 0 means i_event is already synchronous to i_clk and the synchroniser is bypassed.
- C_CNT_W (localparam), clog2(MAX_CNT+1), width of the count and the result.

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_en  in  1  measurement enable
- i_event  in  1  event input; a rising edge marks a period boundary
- i_rdy  in  1  consumer ready for the result
- o_vld  out  1  result valid
- o_period  out  C_CNT_W  captured period in cycles
- o_ovf  out  1  captured period exceeded MAX_CNT; qualified by o_vld
- o_drop  out  1  one-cycle pulse: a result was discarded
- o_busy  out  1  high in the ARMED and MEASURING states

Behaviour:
- Reset: i_rst is asynchronous, active-high; clock is i_clk.
  - On reset, every output goes to 0, the state goes to IDLE, and the counter, synchroniser flops and edge history are cleared.
  - Reset mid-measurement discards the partial count and any pending result.
- Edge detect:
  - i_event passes through SYNC_STAGES flops. The edge pulse is `sync & ~sync_d1`.
  - The edge pulse asserts SYNC_STAGES+1 cycles after i_event rises.
  - The edge history updates in every state, so a level that is already high when enabled does not produce an edge.
- States:
  - IDLE: counter held at 0. i_en=1 → ARMED.
  - ARMED: waits for the first edge. On an edge, the counter loads 1 → MEASURING.
  - MEASURING: counter increments each cycle. On an edge:
    - capture the counter into the result register;
    - capture the overflow-pending bit into o_ovf;
    - reload the counter to 1 and clear overflow-pending;
    - stay in MEASURING.
  - i_en=0 in any state → IDLE next cycle. The counter and overflow-pending are cleared. A pending o_vld result is retained until it is accepted.
- Counting rule: edges N cycles apart (edge pulses at cycles t and t+N) capture o_period=N. Minimum capturable period is 1 (edge pulses on consecutive cycles).
- Saturation:
  - When the counter equals MAX_CNT and no edge occurs, the counter holds at MAX_CNT and overflow-pending is set.
  - A period of exactly MAX_CNT gives o_ovf=0.
  - A period of MAX_CNT+1 or more gives o_period=MAX_CNT and o_ovf=1.
- Output handshake:
  - o_vld rises one cycle after the capturing edge pulse.
  - o_period and o_ovf are stable while o_vld=1 and i_rdy=0.
  - A transfer occurs on o_vld & i_rdy.
  - Capture with o_vld=0: load the result and set o_vld.
  - Capture with o_vld=1 and i_rdy=1 in the same cycle: the new result replaces the old one and o_vld stays 1.
  - Capture with o_vld=1 and i_rdy=0: the new result is discarded, the held result is kept, and o_drop pulses for 1 cycle. Measurement continues uninterrupted.
- Edge while leaving IDLE: an edge in the same cycle i_en rises is not seen (the state is still IDLE). Only edges seen in ARMED start a measurement.

Decomposition:
- Shared package holds:
  - the state enum (IDLE=2'd0, ARMED=2'd1, MEASURING=2'd2);
  - the clog2 width function used for C_CNT_W.
- One sub-module, edge_sync: a parameterised SYNC_STAGES synchroniser plus rising-edge detector with asynchronous reset. It is reusable by other blocks that consume external strobes.
- The FSM, counter and output register stay in period_meter.

Test Plan:
- Periodic ticks: SYNC_STAGES=2, MAX_CNT=255, i_en=1, i_rdy=1, i_event pulsed high 1 cycle every 10 cycles → after the first edge, each subsequent edge yields o_vld for 1 cycle with o_period=10 and o_ovf=0. o_vld occurs 4 cycles after the i_event rise.
- Overflow boundary: MAX_CNT=15, edges 15 apart → o_period=15, o_ovf=0. Edges 16 apart → o_period=15, o_ovf=1. The next 15-cycle period reports o_ovf=0.
- Backpressure: i_rdy=0, edges 5 then 7 cycles apart → o_vld holds o_period=5. o_drop pulses once at the second capture. Raising i_rdy completes the transfer and o_vld falls.
- Simultaneous capture and accept: o_vld=1 holding period 5, i_rdy=1 in the same cycle as a new capture of 8 → next cycle o_vld=1 with o_period=8 and o_drop=0.
- Enable gating: drop i_en mid-period, then re-enable with i_event held high → no result until a fresh rising edge arms the block and a second edge occurs. o_busy=0 while i_en=0.
- Async reset: assert i_rst mid-measurement with o_vld=1 → all outputs 0 immediately, and the state is IDLE after release.
